fifo_sync_param: RTL
====================

# fifo_sync_param

Parametrised single-clock FIFO, successor to the fixed 8-bit FIFO block. It buffers words between a producer and a consumer in the same clock domain. It adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 4.
- AF_LEVEL, DEPTH-2: AFULL asserts when COUNT ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: AEMP asserts when COUNT ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = registered read; 1 = first-word-fall-through.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- WRreq  in  1  write request.
- WRData  in  WIDTH  write data, sampled on the clk edge when a write is accepted.
- RReq  in  1  read request (pop).
- RData  out  WIDTH  read data.
- FULL  out  1  COUNT == DEPTH.
- EMP  out  1  COUNT == 0.
- AFULL  out  1  COUNT ≥ AF_LEVEL.
- AEMP  out  1  COUNT ≤ AE_LEVEL.
- COUNT  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- OVF  out  1  sticky: a write was attempted while FULL.
- UNF  out  1  sticky: a read was attempted while EMP.
- CLRERR  in  1  clears OVF and UNF.

## Operation
- Storage:
  - DEPTH×WIDTH memory.
  - Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - COUNT is a register.
- Accepted write = WRreq & !FULL. It stores WRData at the write pointer, then increments the write pointer.
- Accepted read = RReq & !EMP. It increments the read pointer.
- COUNT update: +1 on write only; −1 on read only; unchanged when both or neither are accepted.
- Flags are decoded combinationally from the registered COUNT, so they change only after a clk edge.
- Rejected write (WRreq & FULL):
  - Memory, pointers and COUNT are unchanged.
  - OVF is set.
  - This holds even when RReq is high in the same cycle. The read is still accepted, so after the edge COUNT = DEPTH-1.
- Rejected read (RReq & EMP):
  - Pointers, COUNT and RData are unchanged.
  - UNF is set.
  - A simultaneous write is still accepted.
- CLRERR clears OVF and UNF at the edge. If a new error occurs in the same cycle, the set wins.
- FWFT=0:
  - RData is a register.
  - On an accepted read, RData is loaded with mem[read pointer].
  - Otherwise RData holds its value.
- FWFT=1:
  - Whenever EMP=0, RData equals mem[read pointer], i.e. the head word.
  - An accepted read advances the head.
  - When EMP=1, RData holds the last word presented.
  - Implement this with a head register that is refreshed on a write into an empty FIFO and on a pop.
- Reset (reset=0 at an edge):
  - Pointers = 0, COUNT = 0, RData = 0, OVF = UNF = 0.
  - Resulting outputs: EMP = 1, AEMP = 1, FULL = 0, AFULL = 0.
  - Memory contents are not cleared.
  - Reset overrides all requests in that cycle, including a reset asserted mid-burst.

## Timing
- Write at edge N:
  - COUNT, flags and EMP deassertion are visible from cycle N+1.
  - In FWFT mode, the word is on RData from cycle N+1 when the FIFO was empty.
- FWFT=0 read at edge M: RData is valid from cycle M+1. The earliest read of a word written at edge N is edge N+1, with data visible at N+2.
- FWFT=1: head data is available with zero cycles of read latency. Popping at edge M presents the next word from M+1.
- Sustained throughput: one write and one read per cycle, with no bubbles at any occupancy between 1 and DEPTH-1.
- Back-to-back full/empty transitions have no dead cycles: FULL deasserts the cycle after a pop from full.

## Test plan
- Fill and drain, DEPTH=16, FWFT=0:
  - Write 2,4,…,32 on 16 consecutive cycles → FULL=1 and COUNT=16 after the 16th edge; AFULL asserts after the 14th.
  - Then 16 reads → RData = 2,4,…,32 in order, each one cycle after its read edge.
  - EMP=1 after the last read; AEMP asserts when COUNT reaches 2.
- Overflow/underflow:
  - Write 0xAA while full → OVF=1, COUNT stays 16, and the drained data contains no 0xAA.
  - Read while empty → UNF=1, RData unchanged.
  - CLRERR → both flags 0 the next cycle.
  - CLRERR concurrent with a new overflow → OVF stays 1.
- Simultaneous read and write:
  - At COUNT=5, 20 cycles of WRreq=RReq=1 → COUNT constant at 5 and order preserved.
  - At full, both requests → OVF=1, COUNT=15.
  - At empty, both requests → UNF=1, COUNT=1.
- Pointer wrap: push and pop 40 words with occupancy kept near 3 → all 40 words are returned in order across two pointer wraps.
- Reset mid-operation: at COUNT=9, drive reset=0 for one edge together with WRreq=1 → COUNT=0, EMP=1, RData=0, OVF=UNF=0, and the write is discarded.
- FWFT=1: write 0x11 at edge N → EMP=0 and RData=0x11 at N+1 with no read issued. Write 0x22, then pop → RData=0x22 next cycle. Pop again → EMP=1, RData holds 0x22.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: request, data, status and error bundle.
// The producer/consumer side uses master; the FIFO uses slave.
interface fifo_sync_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             WRreq;
   logic [WIDTH-1:0] WRData;
   logic             RReq;
   logic [WIDTH-1:0] RData;
   logic             FULL;
   logic             EMP;
   logic             AFULL;
   logic             AEMP;
   logic [CW-1:0]    COUNT;
   logic             OVF;
   logic             UNF;
   logic             CLRERR;

   modport master (
      output WRreq, WRData, RReq, CLRERR,
      input  RData, FULL, EMP, AFULL, AEMP,
      input  COUNT, OVF, UNF
   );

   modport slave (
      input  WRreq, WRData, RReq, CLRERR,
      output RData, FULL, EMP, AFULL, AEMP,
      output COUNT, OVF, UNF
   );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with count, thresholds,
// sticky error flags and optional first-word-fall-through.
module fifo_sync_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input logic              clk,
   input logic              reset,
   fifo_sync_param_if.slave f
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rdata;
   logic             ovf;
   logic             unf;
   logic             full;
   logic             emp;
   logic             wr_ok;
   logic             rd_ok;

   assign full  = count == CW'(DEPTH);
   assign emp   = count == '0;
   assign wr_ok = f.WRreq & ~full;
   assign rd_ok = f.RReq & ~emp;

   assign f.RData = rdata;
   assign f.FULL  = full;
   assign f.EMP   = emp;
   assign f.AFULL = count >= CW'(AF_LEVEL);
   assign f.AEMP  = count <= CW'(AE_LEVEL);
   assign f.COUNT = count;
   assign f.OVF   = ovf;
   assign f.UNF   = unf;

   // Storage is not cleared by reset, but a write in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (reset && wr_ok)
         mem[wptr] <= f.WRData;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         if (wr_ok)
            wptr <= wptr + 1'b1;
         if (rd_ok)
            rptr <= rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new error in the same cycle beats the clear.
         if (f.WRreq & full)
            ovf <= 1'b1;
         else if (f.CLRERR)
            ovf <= 1'b0;
         if (f.RReq & emp)
            unf <= 1'b1;
         else if (f.CLRERR)
            unf <= 1'b0;
      end
   end

   if (FWFT != 0) begin : g_fwft
      logic [AW-1:0] rnext;
      assign rnext = rptr + 1'b1;

      // Head register: the word behind the head is either already
      // in memory or, at occupancy 1, is the word being written now.
      always_ff @(posedge clk) begin
         if (!reset)
            rdata <= '0;
         else if (wr_ok && emp)
            rdata <= f.WRData;
         else if (rd_ok && count > CW'(1))
            rdata <= mem[rnext];
         else if (rd_ok && wr_ok)
            rdata <= f.WRData;
      end
   end else begin : g_reg
      always_ff @(posedge clk) begin
         if (!reset)
            rdata <= '0;
         else if (rd_ok)
            rdata <= mem[rptr];
      end
   end
endmodule
